hazard_track: RTL

Parametrised hazard and forwarding controller for the in-order pipelined processor. It sits beside the decode stage. It keeps a shift-register scoreboard of in-flight register writes and produces:
- load-use stall and bubble control,
- per-read-port forwarding selects,
- a global freeze for multi-cycle data-memory stalls,
- saturating hazard performance counters.

It generalises the fixed two-port EX/MEM/WB compare logic to any register count, read-port count, pipeline depth and load latency.

---
 rtl/hazard_pkg.sv | 39 +++
 rtl/hazard_fwd_match.sv | 50 +++++
 rtl/hazard_track.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller.
// Holds the forwarding-select encoding, the scoreboard entry layout,
// width helpers and the parameter legality check used at elaboration.
package hazard_pkg;

    // Forward select value meaning "use the register-file value".
    localparam int unsigned FWD_RF = 0;

    // Scoreboard entry bit layout, LSB first: {rd, ld, wr, v}.
    localparam int unsigned ENT_V  = 0;
    localparam int unsigned ENT_WR = 1;
    localparam int unsigned ENT_LD = 2;
    localparam int unsigned ENT_RD = 3;

    // Register index width; at least one bit so a one-register file still elaborates.
    function automatic int unsigned reg_w_of(input int unsigned nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

    // Forward select width: encodes 0 (register file) through nstages.
    function automatic int unsigned fwd_w_of(input int unsigned nstages);
        return (nstages >= 1) ? $clog2(nstages + 1) : 1;
    endfunction

    // Width of one flattened scoreboard entry.
    function automatic int unsigned ent_w_of(input int unsigned reg_w);
        return ENT_RD + reg_w;
    endfunction

    // True when the parameter set describes a buildable controller.
    function automatic bit params_ok(input int unsigned nread,
                                     input int unsigned nstages,
                                     input int unsigned load_lat,
                                     input int unsigned cnt_w);
        return (nread >= 1) && (nstages >= 1) && (load_lat >= 1) &&
               (load_lat <= nstages) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/hazard_fwd_match.sv
// One decode read port compared against every scoreboard entry.
// Ports:
//   id_valid  - decode slot holds a real instruction
//   rd_en     - this port actually reads its source register
//   rs        - source register index for this port
//   ent       - all scoreboard entries, index 0 = EX (stage 1)
//   sel       - forward select: youngest matching stage, or FWD_RF
//   load_haz  - youngest match is a load whose data is not yet available
module hazard_fwd_match
    import hazard_pkg::*;
#(
    parameter int unsigned NSTAGES  = 3,
    parameter int unsigned REG_W    = 3,
    parameter int unsigned W_F      = 2,
    parameter int unsigned LOAD_LAT = 2,
    localparam int unsigned ENT_W   = ent_w_of(REG_W)
) (
    input  logic                           id_valid,
    input  logic                           rd_en,
    input  logic [REG_W-1:0]               rs,
    input  logic [NSTAGES-1:0][ENT_W-1:0]  ent,
    output logic [W_F-1:0]                 sel,
    output logic                           load_haz
);

    logic [NSTAGES-1:0] hit;
    logic [NSTAGES-1:0] early_load;

    // Per-stage match and "load data not ready yet" flags.
    for (genvar k = 0; k < NSTAGES; k++) begin : g_ent
        assign hit[k] = ent[k][ENT_V] & ent[k][ENT_WR] &
                        (ent[k][ENT_RD +: REG_W] == rs) & rd_en & id_valid;
        // Stage k+1 precedes the first stage that carries load data.
        assign early_load[k] = ent[k][ENT_LD] & ((k + 1) < LOAD_LAT);
    end

    // Priority encode from oldest to youngest so the youngest writer wins;
    // the hazard flag follows the same winning entry.
    always_comb begin
        sel      = W_F'(FWD_RF);
        load_haz = 1'b0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                sel      = W_F'(k + 1);
                load_haz = early_load[k];
            end
        end
    end

endmodule

// File: rtl/hazard_track.sv
// Hazard and forwarding controller beside the decode stage.
// Keeps a shift-register scoreboard of in-flight register writes and
// derives load-use stalls, bubbles, forwarding selects and a global freeze.
// Ports:
//   clk, rst       - rising-edge clock, asynchronous active-low reset
//   id_valid       - decode slot holds a real instruction
//   id_rd_en       - per-port source-register-used flags
//   id_rs          - source indices, port p at [p*REG_W +: REG_W]
//   id_wr_en/id_wd - decode instruction writes register id_wd
//   id_is_load     - decode instruction is a load
//   flush          - kill the decode instruction (taken branch/jump)
//   mem_stall      - data memory busy, freeze the pipeline
//   stall_id       - hold PC and IF/ID (combinational)
//   bubble_ex      - load a NOP into ID/EX (combinational)
//   freeze         - hold every pipeline latch (combinational)
//   fwd_sel        - per-port forward select, port p at [p*W_F +: W_F] (combinational)
//   cnt_loaduse    - saturating count of load-use stall cycles
//   cnt_memstall   - saturating count of memory-freeze cycles
module hazard_track
    import hazard_pkg::*;
#(
    parameter int unsigned NREGS    = 8,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned NSTAGES  = 3,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 16,
    localparam int unsigned REG_W   = reg_w_of(NREGS),
    localparam int unsigned W_F     = fwd_w_of(NSTAGES)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [NREAD-1:0]       id_rd_en,
    input  logic [NREAD*REG_W-1:0] id_rs,
    input  logic                   id_wr_en,
    input  logic [REG_W-1:0]       id_wd,
    input  logic                   id_is_load,
    input  logic                   flush,
    input  logic                   mem_stall,
    output logic                   stall_id,
    output logic                   bubble_ex,
    output logic                   freeze,
    output logic [NREAD*W_F-1:0]   fwd_sel,
    output logic [CNT_W-1:0]       cnt_loaduse,
    output logic [CNT_W-1:0]       cnt_memstall
);

    localparam int unsigned ENT_W = ent_w_of(REG_W);

    // Reject illegal parameter sets at elaboration.
    if (!params_ok(NREAD, NSTAGES, LOAD_LAT, CNT_W)) begin : g_param_check
        $error("hazard_track: illegal parameters (need NREAD>=1, 1<=LOAD_LAT<=NSTAGES)");
    end

    logic [NSTAGES-1:0][ENT_W-1:0] ent_q;
    logic [ENT_W-1:0]              ent_in;
    logic [NREAD*W_F-1:0]          sel_raw;
    logic [NREAD-1:0]              port_haz;
    logic                          hazard;

    // One matcher per decode read port.
    for (genvar p = 0; p < NREAD; p++) begin : g_port
        hazard_fwd_match #(
            .NSTAGES  (NSTAGES),
            .REG_W    (REG_W),
            .W_F      (W_F),
            .LOAD_LAT (LOAD_LAT)
        ) u_match (
            .id_valid (id_valid),
            .rd_en    (id_rd_en[p]),
            .rs       (id_rs[p*REG_W +: REG_W]),
            .ent      (ent_q),
            .sel      (sel_raw[p*W_F +: W_F]),
            .load_haz (port_haz[p])
        );
    end

    assign hazard = |port_haz;

    // Control priority: mem_stall > flush > hazard; everything quiet in reset
    // except freeze, which always mirrors mem_stall.
    always_comb begin
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        fwd_sel   = '0;
        freeze    = mem_stall;
        if (rst) begin
            fwd_sel   = sel_raw;
            stall_id  = hazard & ~flush & ~mem_stall;
            bubble_ex = (hazard | flush) & ~mem_stall;
        end
    end

    // Entry entering stage 1: the decode instruction, or a bubble when it is
    // invalid, stalled or flushed.
    always_comb begin
        ent_in = '0;
        if (id_valid && !stall_id && !flush) begin
            ent_in[ENT_V]              = 1'b1;
            ent_in[ENT_WR]             = id_wr_en;
            ent_in[ENT_LD]             = id_is_load;
            ent_in[ENT_RD +: REG_W]    = id_wd;
        end
    end

    // Scoreboard shift register; holds completely while memory stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_q <= '0;
        end else if (!mem_stall) begin
            ent_q[0] <= ent_in;
            for (int k = 1; k < NSTAGES; k++) begin
                ent_q[k] <= ent_q[k-1];
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_loaduse  <= '0;
            cnt_memstall <= '0;
        end else begin
            if (stall_id && (cnt_loaduse != '1)) begin
                cnt_loaduse <= cnt_loaduse + CNT_W'(1);
            end
            if (mem_stall && (cnt_memstall != '1)) begin
                cnt_memstall <= cnt_memstall + CNT_W'(1);
            end
        end
    end

endmodule
